// File: rtl/cpu_mem_pkg.sv
// Shared constants for the CPU memory-port arbiter: owner encoding,
// word-address slicing and default parameter values.
package cpu_mem_pkg;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  // Byte address bits below WORD_LSB select a byte within a 32-bit word.
  localparam int WORD_LSB = 2;

  localparam int DEFAULT_AW         = 8;
  localparam int DEFAULT_STARVE_MAX = 3;

endpackage

// File: rtl/starve_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module starve_counter #(
  parameter int MAX = 3,
  parameter int CW  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CW'(MAX))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between fetch and load/store ports.
// Data wins contention unless fetch has been denied STARVE_MAX cycles in a row.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int AW         = DEFAULT_AW,
  parameter int STARVE_MAX = DEFAULT_STARVE_MAX
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [31:0]   i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [31:0]   i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  input  logic [3:0]    d_wstrb,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_wstrb,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;
  logic          force_i;
  logic [1:0]    owner_q;
  logic [1:0]    owner_d;

  starve_counter #(
    .MAX (STARVE_MAX),
    .CW  (CW)
  ) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (i_req & ~i_gnt),
    .clr_i (~i_req | i_gnt),
    .cnt_o (starve_cnt)
  );

  assign force_i = (starve_cnt >= CW'(STARVE_MAX));

  // Fetch wins when alone or when starved; data takes everything else.
  assign i_gnt = i_req & (~d_req | force_i);
  assign d_gnt = d_req & ~(i_req & force_i);

  always_comb begin
    mem_addr = '0;
    if (i_gnt) begin
      mem_addr = i_addr[AW+WORD_LSB-1:WORD_LSB];
    end else if (d_gnt) begin
      mem_addr = d_addr[AW+WORD_LSB-1:WORD_LSB];
    end
  end

  assign mem_en    = i_gnt | d_gnt;
  assign mem_we    = d_gnt & d_we;
  assign mem_wstrb = mem_we ? d_wstrb : 4'b0000;
  assign mem_wdata = d_wdata;

  // Remember who issued the read so the returning word goes to the right port.
  always_comb begin
    owner_d = OWN_NONE;
    if (i_gnt) begin
      owner_d = OWN_I;
    end else if (d_gnt && !d_we) begin
      owner_d = OWN_D;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign i_rvalid = (owner_q == OWN_I);
  assign d_rvalid = (owner_q == OWN_D);
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:AW+WORD_LSB], i_addr[WORD_LSB-1:0],
                              d_addr[31:AW+WORD_LSB], d_addr[WORD_LSB-1:0]};

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory (1-cycle registered read, 32-bit words) between the CPU instruction-fetch port and the load/store port.
- Sits between the cpu core and the unified memory array. It arbitrates each cycle, drives the memory address/write lines, and routes returned read data to the port that issued the read.
- Data port has priority; a starvation counter guarantees forward progress for fetch.

Parameters:
- AW, 8, memory word-address width (memory depth 2^AW words).
- STARVE_MAX, 3, consecutive denied fetch-request cycles after which fetch is forced to win.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_req  in  1  fetch requests a read this cycle.
- i_addr  in  32  fetch byte address.
- i_gnt  out  1  fetch request accepted this cycle (combinational).
- i_rvalid  out  1  i_rdata valid, one cycle after the i_gnt cycle.
- i_rdata  out  32  fetch read data.
- d_req  in  1  load/store request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_wstrb  in  4  store byte enables.
- d_gnt  out  1  data request accepted this cycle (combinational).
- d_rvalid  out  1  d_rdata valid, one cycle after a granted load.
- d_rdata  out  32  load data.
- mem_addr  out  AW  word address = granted addr[AW+1:2].
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  write enable (store granted).
- mem_wstrb  out  4  byte enables; 0 unless mem_we.
- mem_wdata  out  32  = d_wdata.
- mem_rdata  in  32  memory read data, registered inside memory, valid the cycle after access.

Behaviour:
- Reset (async assert, sync release): i_rvalid = d_rvalid = 0, owner = NONE, starve_cnt = 0.
  - Grant outputs are combinational from req inputs and starve_cnt; after reset, d_gnt = d_req and i_gnt = i_req & ~d_req.
  - mem_en / mem_we follow the grants.
- Grant rule, per cycle:
  - force_i = (starve_cnt >= STARVE_MAX).
  - If d_req & i_req: d_gnt = ~force_i, i_gnt = force_i.
  - If only one port requests, that port is granted.
  - At most one grant per cycle. A request held without a grant stays pending; the requester keeps its req/addr/data stable until granted.
- starve_cnt: increments (saturating at STARVE_MAX) each cycle i_req & ~i_gnt. Clears to 0 on any cycle i_gnt = 1 or i_req = 0.
- Memory drive:
  - mem_en = i_gnt | d_gnt.
  - mem_addr comes from the granted port, and is 0 when idle.
  - mem_we = d_gnt & d_we.
  - Address bits [1:0] are ignored (no misalignment fault).
- Read return:
  - owner register latches I on a fetch grant, D on a granted load, NONE otherwise (store or idle).
  - Next cycle: i_rvalid = (owner == I), d_rvalid = (owner == D). Both rdata outputs carry mem_rdata; only the matching rvalid is high.
  - Stores never produce rvalid.
- Throughput: one access per cycle, back-to-back, with no bubbles; a new grant may coincide with the previous rvalid.
- Reset mid-operation: a read granted in the cycle before rst_n falls returns no rvalid; owner is forced to NONE.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - owner encoding constants OWN_NONE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2;
  - the word-address slice helper constants;
  - the default STARVE_MAX.
- One natural sub-module: starve_counter (saturating counter with clear), instantiated once. Everything else stays flat.

Test Plan:
- Idle then single fetch: i_req = 1, i_addr = 0x10 for one cycle -> i_gnt = 1, mem_addr = 4, mem_en = 1. Next cycle i_rvalid = 1, i_rdata = mem[4], d_rvalid = 0.
- Continuous fetch: i_addr = 0x0, 0x4, 0x8 on consecutive cycles -> three grants, then i_rvalid high for three consecutive cycles returning mem[0], mem[1], mem[2] in order.
- Contention with starvation: i_req and d_req (loads) both held high for 6 cycles, STARVE_MAX = 3 -> grants D, D, D, I, D, D (counter clears after the I grant). Each d_rvalid/i_rvalid follows its grant by exactly one cycle.
- Store: d_req = 1, d_we = 1, d_addr = 0x20, d_wdata = 0xDEADBEEF, d_wstrb = 4'b0011 -> mem_we = 1, mem_addr = 8, mem_wstrb = 0011. No rvalid next cycle. A subsequent load of 0x20 returns 0x????BEEF with the upper bytes unchanged.
- Reset mid-read: grant a fetch to 0x40, assert rst_n = 0 before the next edge -> i_rvalid stays 0, all outputs at reset values. After release, a fetch of 0x40 completes normally.
- Misaligned address: d_addr = 0x23 load -> mem_addr = 8, d_rdata = mem[8].
